// File: rtl/frame_painter.sv
// Rectangle-fill engine writing solid colour boxes into the 640x480x8 frame buffer write port.
// Latency: busy one cycle after start is sampled, first pixel write two cycles later, then 1 pixel/clock.
// Backpressure: none on the write port; dropping cmd_start mid-command aborts it. Build option: PAINTER_CLIP_EN.
module frame_painter #(
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        cmd_start,
    input  logic [9:0]  cmd_x,
    input  logic [9:0]  cmd_y,
    input  logic [9:0]  cmd_w,
    input  logic [9:0]  cmd_h,
    input  logic [7:0]  cmd_color,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [18:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        wr_en
);

    typedef enum logic [1:0] {IDLE, CLIP, FILL, DONE} state_t;

    localparam logic [10:0] H_LIM   = 11'(H_RES);
    localparam logic [10:0] V_LIM   = 11'(V_RES);
    localparam logic [18:0] ROW_INC = 19'(H_RES);

    state_t state, state_nxt;

    // latched command
    logic [9:0]  x_q, y_q, w_q, h_q;
    logic [7:0]  color_q;
    logic [9:0]  x_nxt, y_nxt, w_nxt, h_nxt;
    logic [7:0]  color_nxt;

    // fill walker
    logic [10:0] x_end_q, y_end_q, x_end_nxt, y_end_nxt;
    logic [18:0] base_q, base_nxt;
    logic [9:0]  col_q, row_q, col_nxt, row_nxt;
    logic        rej_q, rej_nxt;

    // registered outputs, next values
    logic        busy_nxt, done_nxt, err_nxt, wr_en_nxt;
    logic [18:0] wr_addr_nxt;
    logic [7:0]  wr_data_nxt;

    // clip-stage arithmetic on the latched command
    logic [10:0] sum_x, sum_y, clip_x_end, clip_y_end;
    logic [18:0] row_base;
    logic        zero_size, no_write, reject;
    logic        last_col, last_row;

    assign sum_x     = {1'b0, x_q} + {1'b0, w_q};
    assign sum_y     = {1'b0, y_q} + {1'b0, h_q};
    // y*640 as two shifts, y < 512 so this fits in 19 bits
    assign row_base  = ({9'd0, y_q} << 9) + ({9'd0, y_q} << 7);
    assign zero_size = (w_q == 10'd0) || (h_q == 10'd0);

`ifdef PAINTER_CLIP_EN
    // clipped build: trim to the screen, an off-screen origin is a silent no-op
    assign clip_x_end = (sum_x > H_LIM) ? H_LIM : sum_x;
    assign clip_y_end = (sum_y > V_LIM) ? V_LIM : sum_y;
    assign no_write   = zero_size || ({1'b0, x_q} >= H_LIM) || ({1'b0, y_q} >= V_LIM);
    assign reject     = 1'b0;
`else
    // strict build: anything spilling off-screen is refused with err
    assign clip_x_end = sum_x;
    assign clip_y_end = sum_y;
    assign no_write   = zero_size;
    assign reject     = !zero_size && ((sum_x > H_LIM) || (sum_y > V_LIM));
`endif

    assign last_col = ({1'b0, col_q} + 11'd1) == x_end_q;
    assign last_row = ({1'b0, row_q} + 11'd1) == y_end_q;

    // state register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // next-state: start level drives every transition, low level aborts or releases
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (cmd_start) state_nxt = CLIP;
            CLIP: begin
                if (!cmd_start)            state_nxt = IDLE;
                else if (no_write || reject) state_nxt = DONE;
                else                       state_nxt = FILL;
            end
            FILL: begin
                if (!cmd_start)               state_nxt = IDLE;
                else if (last_col && last_row) state_nxt = DONE;
            end
            DONE: if (!cmd_start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // output/datapath next values: latch, clip, walk the rectangle one pixel per clock
    always_comb begin
        x_nxt       = x_q;
        y_nxt       = y_q;
        w_nxt       = w_q;
        h_nxt       = h_q;
        color_nxt   = color_q;
        x_end_nxt   = x_end_q;
        y_end_nxt   = y_end_q;
        base_nxt    = base_q;
        col_nxt     = col_q;
        row_nxt     = row_q;
        rej_nxt     = rej_q;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;
        wr_en_nxt   = 1'b0;
        wr_addr_nxt = wr_addr;
        wr_data_nxt = wr_data;
        case (state)
            IDLE: begin
                busy_nxt = cmd_start;
                if (cmd_start) begin
                    x_nxt     = cmd_x;
                    y_nxt     = cmd_y;
                    w_nxt     = cmd_w;
                    h_nxt     = cmd_h;
                    color_nxt = cmd_color;
                end
            end
            CLIP: begin
                busy_nxt  = cmd_start;
                x_end_nxt = clip_x_end;
                y_end_nxt = clip_y_end;
                base_nxt  = row_base;
                col_nxt   = x_q;
                row_nxt   = y_q;
                rej_nxt   = reject;
            end
            FILL: begin
                busy_nxt = cmd_start;
                if (cmd_start) begin
                    wr_en_nxt   = 1'b1;
                    wr_addr_nxt = base_q + 19'(col_q);
                    wr_data_nxt = color_q;
                    // row turn folds into the same cycle so there is no bubble
                    if (last_col) begin
                        col_nxt  = x_q;
                        row_nxt  = row_q + 10'd1;
                        base_nxt = base_q + ROW_INC;
                    end else begin
                        col_nxt  = col_q + 10'd1;
                    end
                end
            end
            DONE: begin
                busy_nxt = 1'b0;
                done_nxt = cmd_start;
                err_nxt  = cmd_start && rej_q;
            end
            default: busy_nxt = 1'b0;
        endcase
    end

    // datapath and output registers; async reset drops wr_en immediately
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            x_q     <= '0;
            y_q     <= '0;
            w_q     <= '0;
            h_q     <= '0;
            color_q <= '0;
            x_end_q <= '0;
            y_end_q <= '0;
            base_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            rej_q   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            x_q     <= x_nxt;
            y_q     <= y_nxt;
            w_q     <= w_nxt;
            h_q     <= h_nxt;
            color_q <= color_nxt;
            x_end_q <= x_end_nxt;
            y_end_q <= y_end_nxt;
            base_q  <= base_nxt;
            col_q   <= col_nxt;
            row_q   <= row_nxt;
            rej_q   <= rej_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            err     <= err_nxt;
            wr_en   <= wr_en_nxt;
            wr_addr <= wr_addr_nxt;
            wr_data <= wr_data_nxt;
        end
    end

endmodule

// File: tb/tb_frame_painter.sv
// Directed bench for frame_painter: hand-computed fills, boundaries, abort and reset.
// Inputs driven and outputs sampled on the falling clock edge.
// Every wait on the DUT is bounded by a cycle budget.
module tb_frame_painter;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        cmd_start;
    logic [9:0]  cmd_x, cmd_y, cmd_w, cmd_h;
    logic [7:0]  cmd_color;
    logic        busy, done, err, wr_en;
    logic [18:0] wr_addr;
    logic [7:0]  wr_data;

    int checks   = 0;
    int failures = 0;
    int got_addr[$];

    always #5 Clk = ~Clk;

    frame_painter dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .cmd_start(cmd_start),
        .cmd_x    (cmd_x),
        .cmd_y    (cmd_y),
        .cmd_w    (cmd_w),
        .cmd_h    (cmd_h),
        .cmd_color(cmd_color),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_en    (wr_en)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic drive(input int x, input int y, input int w, input int h, input int c);
        cmd_x     = 10'(x);
        cmd_y     = 10'(y);
        cmd_w     = 10'(w);
        cmd_h     = 10'(h);
        cmd_color = 8'(c);
        cmd_start = 1'b1;
    endtask

    // Runs one command to completion and release. eff_w is the width actually
    // painted (after any clipping), used by the address model.
    task automatic run_cmd(input string tag, input int x, input int y, input int w, input int h,
                           input int c, input int eff_w, input int exp_n, input int exp_last,
                           input bit exp_err, input bit pre_driven);
        int n = 0, first = -1, lastw = -1, done_cyc = -1;
        int gaps = 0, addr_bad = 0, data_bad = 0, last_a = -1;
        int ci = 0, ri = 0, exp_a;
        if (!pre_driven) begin
            @(negedge Clk);
            drive(x, y, w, h, c);
        end
        got_addr.delete();
        for (int cyc = 0; cyc < 9000 && done_cyc < 0; cyc++) begin
            @(negedge Clk);
            if (cyc == 0) chk({tag, ":busy_after_start"}, {31'd0, busy}, 32'd1);
            if (wr_en === 1'b1) begin
                if (first < 0) first = cyc;
                else if (lastw != cyc - 1) gaps++;
                lastw = cyc;
                n++;
                last_a = int'(wr_addr);
                got_addr.push_back(int'(wr_addr));
                exp_a = (y + ri) * 640 + x + ci;
                if (int'(wr_addr) != exp_a) addr_bad++;
                if (wr_data !== 8'(c)) data_bad++;
                ci++;
                if (ci == eff_w) begin
                    ci = 0;
                    ri++;
                end
            end
            if (done === 1'b1) done_cyc = cyc;
        end
        chk({tag, ":done_seen"}, {31'd0, done_cyc >= 0}, 32'd1);
        chk({tag, ":writes"}, 32'(n), 32'(exp_n));
        if (exp_n > 0) begin
            chk({tag, ":first_wr_cycle"}, 32'(first), 32'd2);
            chk({tag, ":done_after_last"}, 32'(done_cyc), 32'(lastw + 1));
            chk({tag, ":gaps"}, 32'(gaps), 32'd0);
            chk({tag, ":addr_seq"}, 32'(addr_bad), 32'd0);
            chk({tag, ":data"}, 32'(data_bad), 32'd0);
            chk({tag, ":last_addr"}, 32'(last_a), 32'(exp_last));
        end else begin
            chk({tag, ":done_cycle"}, 32'(done_cyc), 32'd2);
        end
        chk({tag, ":err"}, {31'd0, err}, {31'd0, exp_err});
        chk({tag, ":busy_at_done"}, {31'd0, busy}, 32'd0);
        cmd_start = 1'b0;
        @(negedge Clk);
        chk({tag, ":done_release"}, {31'd0, done}, 32'd0);
        chk({tag, ":err_release"}, {31'd0, err}, 32'd0);
    endtask

    initial begin
        int n;
        bit seen;
        int exp6[6];
        exp6 = '{1290, 1291, 1292, 1930, 1931, 1932};

        Reset_n   = 1'b0;
        cmd_start = 1'b0;
        cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
        repeat (2) @(negedge Clk);
        chk("rst:busy", {31'd0, busy}, 32'd0);
        chk("rst:done", {31'd0, done}, 32'd0);
        chk("rst:err", {31'd0, err}, 32'd0);
        chk("rst:wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst:wr_addr", {13'd0, wr_addr}, 32'd0);
        chk("rst:wr_data", {24'd0, wr_data}, 32'd0);
        Reset_n = 1'b1;

        // 3x2 box straddling a row turn
        run_cmd("small", 10, 2, 3, 2, 8'h5A, 3, 6, 1932, 1'b0, 1'b0);
        chk("small:count", 32'(got_addr.size()), 32'd6);
        for (int i = 0; i < 6 && i < got_addr.size(); i++)
            chk($sformatf("small:addr%0d", i), 32'(got_addr[i]), 32'(exp6[i]));

        // exact fit on the right edge is in range in both builds
        run_cmd("right_edge", 600, 0, 40, 2, 8'hA5, 40, 80, 1279, 1'b0, 1'b0);
        // full-width band down to the last row, ends on the final pixel
        run_cmd("bottom_band", 0, 470, 640, 10, 8'hFF, 640, 6400, 307199, 1'b0, 1'b0);
        // zero width is a no-op
        run_cmd("zero_w", 3, 4, 0, 5, 8'h11, 1, 0, 0, 1'b0, 1'b0);

`ifdef PAINTER_CLIP_EN
        run_cmd("oor", 630, 475, 20, 10, 8'h42, 10, 50, 479 * 640 + 639, 1'b0, 1'b0);
        run_cmd("x700", 700, 0, 4, 4, 8'h42, 1, 0, 0, 1'b0, 1'b0);
`else
        run_cmd("oor", 630, 475, 20, 10, 8'h42, 1, 0, 0, 1'b1, 1'b0);
        run_cmd("x700", 700, 0, 4, 4, 8'h42, 1, 0, 0, 1'b1, 1'b0);
`endif

        // abort after four writes of a 10x10 fill
        @(negedge Clk);
        drive(0, 0, 10, 10, 8'h33);
        n = 0;
        for (int cyc = 0; cyc < 50 && n < 4; cyc++) begin
            @(negedge Clk);
            if (wr_en === 1'b1) n++;
        end
        chk("abort:writes_before", 32'(n), 32'd4);
        cmd_start = 1'b0;
        @(negedge Clk);
        chk("abort:wr_en_low", {31'd0, wr_en}, 32'd0);
        chk("abort:busy_low", {31'd0, busy}, 32'd0);
        seen = 1'b0;
        n = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge Clk);
            if (done === 1'b1) seen = 1'b1;
            if (wr_en === 1'b1) n++;
        end
        chk("abort:done_never", {31'd0, seen}, 32'd0);
        chk("abort:no_more_writes", 32'(n), 32'd0);
        run_cmd("after_abort", 5, 1, 2, 1, 8'h77, 2, 2, 646, 1'b0, 1'b0);

        // reset in the middle of a fill
        @(negedge Clk);
        drive(0, 0, 10, 10, 8'h99);
        n = 0;
        for (int cyc = 0; cyc < 50 && n < 3; cyc++) begin
            @(negedge Clk);
            if (wr_en === 1'b1) n++;
        end
        chk("rst_mid:writes_before", 32'(n), 32'd3);
        #2 Reset_n = 1'b0;
        #1;
        chk("rst_mid:wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_mid:busy", {31'd0, busy}, 32'd0);
        chk("rst_mid:done", {31'd0, done}, 32'd0);
        chk("rst_mid:err", {31'd0, err}, 32'd0);
        chk("rst_mid:wr_addr", {13'd0, wr_addr}, 32'd0);
        chk("rst_mid:wr_data", {24'd0, wr_data}, 32'd0);
        drive(20, 3, 3, 1, 8'hC3);
        @(negedge Clk);
        Reset_n = 1'b1;
        run_cmd("after_reset", 20, 3, 3, 1, 8'hC3, 3, 3, 1942, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
